cmp_pipe: RTL and testbench

- Parametrised, pipelined successor to the 4-bit combinational X/Y comparator.
- Computes X−Y status flags (V, N, Z, C) and relational results (lt/eq/gt) with a per-transaction signed/unsigned mode.
- Uses a valid/ready handshake on input and output, and keeps saturating per-outcome event counters.
- Sits between a data source and a downstream consumer in the datapath.

---
 rtl/cmp_pkg.sv | 27 ++
 rtl/cmp_flags.sv | 33 +++
 rtl/cmp_pipe.sv | 135 +++++++++++++
 tb/tb_cmp_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the pipelined X/Y comparator: flag bit positions,
// the relation bundle and a saturating increment helper for the counters.
package cmp_pkg;

    // Bit positions inside the packed flag vector.
    localparam int FLG_V  = 0;
    localparam int FLG_N  = 1;
    localparam int FLG_Z  = 2;
    localparam int FLG_C  = 3;
    localparam int FLAG_W = 4;

    // One-hot relational result; exactly one field is set for a valid result.
    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } rel_t;

    // Returns value+1, or value unchanged once it has reached 2^width-1.
    // Operates on a 32-bit container; callers cast to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/cmp_flags.sv
// Combinational flag and relation decode for X-Y, given the precomputed
// difference, borrow and operand sign bits.
module cmp_flags
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]  d,
    input  logic              b,
    input  logic              x_msb,
    input  logic              y_msb,
    input  logic              is_signed,
    output logic [FLAG_W-1:0] flags,
    output rel_t              rel
);

    // Decode status flags, then derive the mode-dependent relation from them.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        flags = '0;
        rel   = '0;

        flags[FLG_Z] = (d == '0);
        flags[FLG_N] = d[WIDTH-1];
        flags[FLG_C] = b;
        flags[FLG_V] = (x_msb != y_msb) && (d[WIDTH-1] != x_msb);

        rel.eq = flags[FLG_Z];
        rel.lt = is_signed ? (flags[FLG_N] ^ flags[FLG_V]) : flags[FLG_C];
        rel.gt = !rel.lt && !rel.eq;
    end

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage pipelined X/Y comparator with valid/ready handshakes on both
// sides and saturating per-outcome counters of delivered results.
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             flag_v,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    input  logic             clr,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gt_cnt
);

    // Stage 1: difference, borrow and the operand sign bits. Only the MSBs of
    // x/y are ever consumed downstream (for overflow), so only they are kept.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_d;
    logic             s1_b;
    logic             s1_x_msb;
    logic             s1_y_msb;
    logic             s1_signed;

    // Stage 2: registered flags and relation driving the outputs.
    logic [FLAG_W-1:0] s2_flags;
    rel_t              s2_rel;

    logic [FLAG_W-1:0] flags_next;
    rel_t              rel_next;
    logic [WIDTH:0]    diff_ext;
    logic              adv2;
    logic              in_fire;
    logic              out_fire;

    // Zero-extended subtract: the extra top bit is the borrow (x < y unsigned).
    assign diff_ext = {1'b0, x} - {1'b0, y};

    assign adv2     = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv2;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    cmp_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .d         (s1_d),
        .b         (s1_b),
        .x_msb     (s1_x_msb),
        .y_msb     (s1_y_msb),
        .is_signed (s1_signed),
        .flags     (flags_next),
        .rel       (rel_next)
    );

    // Stage 1 capture: load on input transfer, drain when stage 2 takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            s1_valid  <= 1'b0;
            s1_d      <= '0;
            s1_b      <= 1'b0;
            s1_x_msb  <= 1'b0;
            s1_y_msb  <= 1'b0;
            s1_signed <= 1'b0;
        end else if (in_fire) begin
            s1_valid  <= 1'b1;
            s1_d      <= diff_ext[WIDTH-1:0];
            s1_b      <= diff_ext[WIDTH];
            s1_x_msb  <= x[WIDTH-1];
            s1_y_msb  <= y[WIDTH-1];
            s1_signed <= is_signed;
        end else if (adv2) begin
            s1_valid  <= 1'b0;
        end
    end

    // Stage 2 capture: advance whenever the output slot is free or draining;
    // data only changes when a real result moves in, so outputs hold on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            s2_flags  <= '0;
            s2_rel    <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                s2_flags <= flags_next;
                s2_rel   <= rel_next;
            end
        end
    end

    // Outcome counters: clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lt_cnt <= '0;
            eq_cnt <= '0;
            gt_cnt <= '0;
        end else if (clr) begin
            lt_cnt <= '0;
            eq_cnt <= '0;
            gt_cnt <= '0;
        end else if (out_fire) begin
            if (s2_rel.lt) lt_cnt <= CNT_W'(sat_inc(32'(lt_cnt), CNT_W));
            if (s2_rel.eq) eq_cnt <= CNT_W'(sat_inc(32'(eq_cnt), CNT_W));
            if (s2_rel.gt) gt_cnt <= CNT_W'(sat_inc(32'(gt_cnt), CNT_W));
        end
    end

    assign flag_v = s2_flags[FLG_V];
    assign flag_n = s2_flags[FLG_N];
    assign flag_z = s2_flags[FLG_Z];
    assign flag_c = s2_flags[FLG_C];
    assign lt     = s2_rel.lt;
    assign eq     = s2_rel.eq;
    assign gt     = s2_rel.gt;

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed self-checking bench for cmp_pipe. A second instance with 2-bit
// counters shares all inputs and is used for the saturation checks.
module tb_cmp_pipe;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             is_signed;
    logic             out_ready;
    logic             clr;

    logic       in_ready, out_valid, flag_v, flag_n, flag_z, flag_c, lt, eq, gt;
    logic [7:0] lt_cnt, eq_cnt, gt_cnt;

    logic       in_ready2, out_valid2, flag_v2, flag_n2, flag_z2, flag_c2, lt2, eq2, gt2;
    logic [1:0] lt_cnt2, eq_cnt2, gt_cnt2;

    int errors = 0;
    int checks = 0;

    // Expected counter values for the 8-bit instance.
    int exp_lt = 0;
    int exp_eq = 0;
    int exp_gt = 0;

    always #5 clk = ~clk;

    cmp_pipe #(.WIDTH(WIDTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .is_signed(is_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
        .lt(lt), .eq(eq), .gt(gt), .clr(clr),
        .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .gt_cnt(gt_cnt)
    );

    cmp_pipe #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .x(x), .y(y), .is_signed(is_signed),
        .out_valid(out_valid2), .out_ready(out_ready),
        .flag_v(flag_v2), .flag_n(flag_n2), .flag_z(flag_z2), .flag_c(flag_c2),
        .lt(lt2), .eq(eq2), .gt(gt2), .clr(clr),
        .lt_cnt(lt_cnt2), .eq_cnt(eq_cnt2), .gt_cnt(gt_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction with out_ready=1. exp_flags is {C,Z,N,V},
    // exp_rel is {lt,eq,gt}. do_clr asserts clr on the output-transfer edge.
    task automatic compare_one(input string tag, input logic [3:0] xv, input logic [3:0] yv,
                               input logic sg, input logic [3:0] exp_flags,
                               input logic [2:0] exp_rel, input logic do_clr);
        out_ready = 1'b1;
        x = xv; y = yv; is_signed = sg; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, ".lat1"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".flags"}, {28'd0, flag_c, flag_z, flag_n, flag_v}, {28'd0, exp_flags});
        check({tag, ".rel"}, {29'd0, lt, eq, gt}, {29'd0, exp_rel});
        clr = do_clr;
        tick();
        clr = 1'b0;
        if (do_clr) begin
            exp_lt = 0; exp_eq = 0; exp_gt = 0;
        end else begin
            exp_lt += int'(exp_rel[2]);
            exp_eq += int'(exp_rel[1]);
            exp_gt += int'(exp_rel[0]);
        end
        check({tag, ".drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, ".lt_cnt"}, {24'd0, lt_cnt}, exp_lt);
        check({tag, ".eq_cnt"}, {24'd0, eq_cnt}, exp_eq);
        check({tag, ".gt_cnt"}, {24'd0, gt_cnt}, exp_gt);
    endtask

    // Backpressure stream: {x, y, expected {lt,eq,gt}}, all unsigned.
    logic [3:0] bp_x   [4] = '{4'd1, 4'd3, 4'd2, 4'd5};
    logic [3:0] bp_y   [4] = '{4'd1, 4'd2, 4'd3, 4'd5};
    logic [2:0] bp_rel [4] = '{3'b010, 3'b001, 3'b100, 3'b010};

    initial begin
        int snd;
        int rcv;
        logic acc;
        logic del;

        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; is_signed = 1'b0;
        out_ready = 1'b0; clr = 1'b0;
        #12;
        check("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check("reset.in_ready", {31'd0, in_ready}, 32'd1);
        check("reset.outs", {25'd0, flag_c, flag_z, flag_n, flag_v, lt, eq, gt}, 32'd0);
        check("reset.cnts", {8'd0, lt_cnt, eq_cnt, gt_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Directed single compares.
        compare_one("t1_eq_u",   4'b0100, 4'b0100, 1'b0, 4'b0100, 3'b010, 1'b0);
        check_counts("t1");
        compare_one("t2_lt_s",   4'b0010, 4'b0110, 1'b1, 4'b1010, 3'b100, 1'b0);
        check_counts("t2");
        compare_one("t3_gt_s",   4'b0100, 4'b0001, 1'b1, 4'b0000, 3'b001, 1'b0);
        compare_one("t4_ovf_s",  4'b1000, 4'b0001, 1'b1, 4'b0001, 3'b100, 1'b0);
        compare_one("t4_ovf_u",  4'b1000, 4'b0001, 1'b0, 4'b0001, 3'b001, 1'b0);
        compare_one("t4b_lt_u",  4'b0010, 4'b0110, 1'b0, 4'b1010, 3'b100, 1'b0);
        compare_one("bnd_s",     4'b0111, 4'b1000, 1'b1, 4'b1011, 3'b001, 1'b0);
        compare_one("bnd_u",     4'b0111, 4'b1000, 1'b0, 4'b1011, 3'b100, 1'b0);
        check_counts("t4");

        // Backpressure: fill the pipe with the consumer stalled.
        out_ready = 1'b0;
        snd = 0;
        rcv = 0;
        x = bp_x[0]; y = bp_y[0]; is_signed = 1'b0; in_valid = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                snd++;
                x = bp_x[snd]; y = bp_y[snd];
            end
        end
        check("bp.accepted", snd, 32'd2);
        check("bp.in_ready", {31'd0, in_ready}, 32'd0);
        check("bp.hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp.hold_rel", {29'd0, lt, eq, gt}, {29'd0, bp_rel[0]});

        // Release the consumer and collect every result in order.
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 40 && rcv < 4; c++) begin
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            if (del) begin
                check($sformatf("bp.res%0d", rcv), {29'd0, lt, eq, gt}, {29'd0, bp_rel[rcv]});
                exp_lt += int'(bp_rel[rcv][2]);
                exp_eq += int'(bp_rel[rcv][1]);
                exp_gt += int'(bp_rel[rcv][0]);
                rcv++;
            end
            tick();
            if (acc) begin
                snd++;
                if (snd < 4) begin
                    x = bp_x[snd]; y = bp_y[snd];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("bp.received", rcv, 32'd4);
        tick();
        check("bp.no_dup", {31'd0, out_valid}, 32'd0);
        check_counts("bp");

        // Saturation on the 2-bit counter instance; start from a clean slate.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_lt = 0; exp_eq = 0; exp_gt = 0;
        check("clr.eq_cnt2", {30'd0, eq_cnt2}, 32'd0);
        for (int i = 0; i < 5; i++)
            compare_one($sformatf("sat%0d", i), 4'd9, 4'd9, 1'b0, 4'b0100, 3'b010, 1'b0);
        check("sat.eq_cnt2", {30'd0, eq_cnt2}, 32'd3);
        check("sat.eq_cnt8", {24'd0, eq_cnt}, 32'd5);
        compare_one("sat_clr", 4'd9, 4'd9, 1'b0, 4'b0100, 3'b010, 1'b1);
        check("clr_prio.eq_cnt2", {30'd0, eq_cnt2}, 32'd0);
        check_counts("clr_prio");

        // Asynchronous reset with a result waiting at the output.
        compare_one("pre_rst", 4'd3, 4'd3, 1'b0, 4'b0100, 3'b010, 1'b0);
        check("pre_rst.eq_cnt", {24'd0, eq_cnt}, 32'd1);
        out_ready = 1'b0;
        x = 4'd6; y = 4'd2; in_valid = 1'b1;
        tick();
        x = 4'd1; y = 4'd7;
        tick();
        in_valid = 1'b0;
        check("pre_rst.valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst.out_valid", {31'd0, out_valid}, 32'd0);
        check("arst.in_ready", {31'd0, in_ready}, 32'd1);
        check("arst.cnts", {8'd0, lt_cnt, eq_cnt, gt_cnt}, 32'd0);
        check("arst.outs", {25'd0, flag_c, flag_z, flag_n, flag_v, lt, eq, gt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("post_rst.discard", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
